checkpoint_map_table: RTL and testbench
=======================================

Name: checkpoint_map_table

Overview:
- Speculative rename map table with NUM_CHECKPOINTS branch checkpoints, for single-cycle mispredict recovery without waiting for retire.
- Sits between dispatch (rename writes, branch checkpoint requests) and the branch unit (resolve and mispredict).
- The full-table restore from the architected map table is kept for exceptions and flushes.
- Checkpoint ready bits keep snooping the CDB, so a restored table never loses completed tags.

Parameters:
- NUM_WRITE_PORTS, `N: rename write ports per cycle.
- NUM_READ_PORTS, 2*`N: source-operand read ports.
- NUM_CHECKPOINTS, 4: number of checkpoint slots. Must be a power of 2 and at least 2.
- CKPT_IDX_W, $clog2(NUM_CHECKPOINTS): checkpoint ID width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- write_enables  in  NUM_WRITE_PORTS  rename write valid, one per port.
- write_addrs  in  NUM_WRITE_PORTS x REG_IDX  destination architectural register.
- write_phys_regs  in  NUM_WRITE_PORTS x PHYS_TAG  newly allocated physical tag.
- read_addrs  in  NUM_READ_PORTS x REG_IDX  source architectural register.
- read_entries  out  NUM_READ_PORTS x MAP_ENTRY  current mapping and ready bit.
- cdb_broadcasts  in  `N x CDB_ENTRY  completing tags.
- ckpt_req  in  1  take a checkpoint this cycle (at most one branch per cycle).
- ckpt_port  in  $clog2(NUM_WRITE_PORTS)  the checkpoint includes writes on ports 0..ckpt_port.
- ckpt_avail  out  1  a free slot exists at head.
- ckpt_id  out  CKPT_IDX_W  ID the next checkpoint receives (equals head).
- resolve_valid  in  1  branch resolution.
- resolve_id  in  CKPT_IDX_W  checkpoint of the resolving branch.
- resolve_mispredict  in  1  1 = restore from the checkpoint; 0 = free it only.
- table_restore_en  in  1  full restore (exception or flush).
- table_restore  in  ARCH_REG_SZ x MAP_ENTRY  architected table contents.
- table_snapshot  out  ARCH_REG_SZ x MAP_ENTRY  current table.
- ckpt_count  out  CKPT_IDX_W+1  occupied span from tail to head.

Behaviour:
Reset (reset==0 at posedge):
- Entry i maps to PHYS_TAG'(i) with ready=1.
- All checkpoint valid bits are cleared; head=tail=0.
- Outputs after reset: ckpt_avail=1, ckpt_id=0, ckpt_count=0.
- A reset asserted mid-operation discards all checkpoints.

Reads:
- Combinational from the registered table, with no same-cycle bypass of write ports.

Next-state order (normal cycle):
1. CDB ready update on every table entry and every valid checkpoint entry.
2. Apply write ports in ascending index order; a higher index wins on the same address.
3. New mapping ready = (tag matches a valid CDB entry this cycle).
4. Writes to architectural register 0 are ignored; x0 stays tag 0 and ready.

Checkpoint take (ckpt_req && ckpt_avail):
- slot[head] = CDB-updated table plus writes on ports 0..ckpt_port only.
- valid[head] <= 1; head <= head+1 (mod NUM_CHECKPOINTS).
- ckpt_req while !ckpt_avail is ignored. Dispatch must stall; the bench flags it as an error.

Checkpoint allocation and freeing:
- ckpt_avail = !valid[head].
- Correct resolve clears valid[resolve_id] only.
- tail advances past invalid entries; at most one step per cycle is sufficient.
- A slot freed out of order is not reusable until tail passes it.

Mispredict (resolve_valid && resolve_mispredict && valid[resolve_id]):
- table <= slot[resolve_id], OR'ing in this cycle's CDB matches.
- Clear valid for resolve_id and every younger slot (resolve_id through head-1, circular).
- head <= resolve_id.
- This cycle's write ports and ckpt_req are dropped.

Invalid resolves:
- Resolve with valid[resolve_id]==0 is ignored entirely.

Priority (highest first):
1. reset
2. table_restore_en: load table_restore, clear all checkpoints, head=tail=0.
3. mispredict
4. normal update

ckpt_count arithmetic:
- ckpt_count = head-tail (mod 2*NUM_CHECKPOINTS, using an extra wrap bit on both pointers).
- Full when ckpt_count == NUM_CHECKPOINTS.

Latency:
- All state updates are visible on read ports the cycle after the posedge.

Test Plan:
- Reset with reset=0 for 2 cycles -> read x5 returns tag 5, ready=1; ckpt_id=0; ckpt_avail=1.
- Write x3->tag 40 on port 0 with ckpt_req=1, ckpt_port=0, while port 1 writes x4->tag 41 -> slot0 has x3=40 and x4=4. Then mispredict with id 0 -> x3=40 ready=0, x4=4.
- Take a checkpoint with x7=tag 50 not ready, CDB tag 50 two cycles later, then mispredict to that checkpoint -> x7=50 ready=1.
- Take 4 checkpoints -> ckpt_avail=0, ckpt_count=4. Correct resolve id 2 -> ckpt_avail stays 0. Correct resolve id 0 -> tail passes 0 only, ckpt_avail=1.
- Checkpoints 0..3 live, mispredict id 1 -> slots 1,2,3 invalid, head=1, ckpt_count=1. Same-cycle write x9->60 is dropped.
- table_restore_en=1 together with a mispredict and a write -> table equals table_restore, ckpt_count=0.
- Separately, a write to x0 -> x0 remains tag 0, ready=1.

Source files
------------

// File: rtl/checkpoint_map_table.sv
// Speculative rename map with circular branch checkpoints for single-cycle mispredict recovery.
// Latency: reads are combinational from registered state; all updates are visible the cycle after the edge.
// Backpressure: ckpt_avail low means no free slot; a ckpt_req seen then is dropped and dispatch must stall.
module checkpoint_map_table #(
    parameter int NUM_WRITE_PORTS = 2,
    parameter int NUM_READ_PORTS  = 2 * NUM_WRITE_PORTS,
    parameter int NUM_CHECKPOINTS = 4,
    parameter int ARCH_REG_SZ     = 32,
    parameter int PHYS_TAG_W      = 7,
    localparam int CKPT_IDX_W     = $clog2(NUM_CHECKPOINTS),
    localparam int REG_IDX_W      = $clog2(ARCH_REG_SZ),
    localparam int MAP_W          = PHYS_TAG_W + 1,
    localparam int CDB_W          = PHYS_TAG_W + 1,
    localparam int CKPT_PORT_W    = (NUM_WRITE_PORTS > 1) ? $clog2(NUM_WRITE_PORTS) : 1
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUM_WRITE_PORTS-1:0]                    write_enables,
    input  logic [NUM_WRITE_PORTS-1:0][REG_IDX_W-1:0]     write_addrs,
    input  logic [NUM_WRITE_PORTS-1:0][PHYS_TAG_W-1:0]    write_phys_regs,
    input  logic [NUM_READ_PORTS-1:0][REG_IDX_W-1:0]      read_addrs,
    output logic [NUM_READ_PORTS-1:0][MAP_W-1:0]          read_entries,
    input  logic [NUM_WRITE_PORTS-1:0][CDB_W-1:0]         cdb_broadcasts,
    input  logic                                          ckpt_req,
    input  logic [CKPT_PORT_W-1:0]                        ckpt_port,
    output logic                                          ckpt_avail,
    output logic [CKPT_IDX_W-1:0]                         ckpt_id,
    input  logic                                          resolve_valid,
    input  logic [CKPT_IDX_W-1:0]                         resolve_id,
    input  logic                                          resolve_mispredict,
    input  logic                                          table_restore_en,
    input  logic [ARCH_REG_SZ-1:0][MAP_W-1:0]             table_restore,
    output logic [ARCH_REG_SZ-1:0][MAP_W-1:0]             table_snapshot,
    output logic [CKPT_IDX_W:0]                           ckpt_count
);

    // Map entry layout: physical tag above, ready flag in bit 0.
    typedef struct packed {
        logic [PHYS_TAG_W-1:0] tag;
        logic                  ready;
    } map_entry_t;

    map_entry_t                 tbl_q   [ARCH_REG_SZ];
    map_entry_t                 slot_q  [NUM_CHECKPOINTS][ARCH_REG_SZ];
    logic [NUM_CHECKPOINTS-1:0] valid_q;
    logic [CKPT_IDX_W:0]        head_q;
    logic [CKPT_IDX_W:0]        tail_q;

    map_entry_t                 tbl_cdb  [ARCH_REG_SZ];
    map_entry_t                 tbl_nxt  [ARCH_REG_SZ];
    map_entry_t                 snap_nxt [ARCH_REG_SZ];
    map_entry_t                 slot_cdb [NUM_CHECKPOINTS][ARCH_REG_SZ];
    logic [NUM_CHECKPOINTS-1:0] valid_nxt;
    logic [NUM_CHECKPOINTS-1:0] kill;
    logic [CKPT_IDX_W-1:0]      head_idx;
    logic [CKPT_IDX_W-1:0]      tail_idx;
    logic [CKPT_IDX_W:0]        rec_head;
    logic [CKPT_IDX_W:0]        kill_span;
    logic                       mispredict;
    logic                       free_hit;
    logic                       take;
    logic                       tail_adv;

    function automatic logic cdb_hit(input logic [NUM_WRITE_PORTS-1:0][CDB_W-1:0] cdb,
                                     input logic [PHYS_TAG_W-1:0]                 tag);
        logic h;
        h = 1'b0;
        for (int c = 0; c < NUM_WRITE_PORTS; c++) begin
            h = h | (cdb[c][CDB_W-1] && (cdb[c][PHYS_TAG_W-1:0] == tag));
        end
        return h;
    endfunction

    assign head_idx   = head_q[CKPT_IDX_W-1:0];
    assign tail_idx   = tail_q[CKPT_IDX_W-1:0];
    assign mispredict = resolve_valid && resolve_mispredict && valid_q[resolve_id];
    assign free_hit   = resolve_valid && !resolve_mispredict && valid_q[resolve_id];
    assign take       = ckpt_req && !valid_q[head_idx];
    // Tail only walks over slots already freed; one step per cycle keeps up with one take per cycle.
    assign tail_adv   = (tail_q != head_q) && !valid_q[tail_idx];
    // A valid resolve_id lies in [tail, head), so its distance from tail rebuilds the wrap bit.
    assign rec_head   = tail_q + {1'b0, resolve_id - tail_idx};
    assign kill_span  = head_q - rec_head;

    assign ckpt_avail = !valid_q[head_idx];
    assign ckpt_id    = head_idx;
    assign ckpt_count = head_q - tail_q;

    // Drive read ports and the full-table snapshot straight from the registered table.
    always_comb begin
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            read_entries[r] = tbl_q[read_addrs[r]];
        end
        for (int i = 0; i < ARCH_REG_SZ; i++) begin
            table_snapshot[i] = tbl_q[i];
        end
    end

    // Normal next table: CDB wakeup first, then writes in port order; the snapshot sees ports 0..ckpt_port.
    always_comb begin
        for (int i = 0; i < ARCH_REG_SZ; i++) begin
            tbl_cdb[i]       = tbl_q[i];
            tbl_cdb[i].ready = tbl_q[i].ready | cdb_hit(cdb_broadcasts, tbl_q[i].tag);
        end
        tbl_nxt  = tbl_cdb;
        snap_nxt = tbl_cdb;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (write_enables[p] && (write_addrs[p] != '0)) begin
                tbl_nxt[write_addrs[p]] = '{tag: write_phys_regs[p],
                                            ready: cdb_hit(cdb_broadcasts, write_phys_regs[p])};
                if (p <= int'(ckpt_port)) begin
                    snap_nxt[write_addrs[p]] = '{tag: write_phys_regs[p],
                                                 ready: cdb_hit(cdb_broadcasts, write_phys_regs[p])};
                end
            end
        end
    end

    // Checkpoint copies keep snooping the CDB so a restore never loses a completion.
    always_comb begin
        for (int k = 0; k < NUM_CHECKPOINTS; k++) begin
            for (int i = 0; i < ARCH_REG_SZ; i++) begin
                slot_cdb[k][i]       = slot_q[k][i];
                slot_cdb[k][i].ready = slot_q[k][i].ready | cdb_hit(cdb_broadcasts, slot_q[k][i].tag);
            end
        end
    end

    // Valid bits: a mispredict kills resolve_id and everything younger; otherwise free and allocate.
    always_comb begin
        for (int k = 0; k < NUM_CHECKPOINTS; k++) begin
            kill[k] = {1'b0, CKPT_IDX_W'(k) - resolve_id} < kill_span;
        end
        valid_nxt = valid_q;
        if (mispredict) begin
            valid_nxt = valid_q & ~kill;
        end else begin
            if (free_hit) valid_nxt[resolve_id] = 1'b0;
            if (take)     valid_nxt[head_idx]   = 1'b1;
        end
    end

    // Table and pointer state with reset > full restore > mispredict > normal priority.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ARCH_REG_SZ; i++) begin
                tbl_q[i] <= '{tag: PHYS_TAG_W'(i), ready: 1'b1};
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (table_restore_en) begin
            for (int i = 0; i < ARCH_REG_SZ; i++) begin
                tbl_q[i] <= table_restore[i];
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            valid_q <= valid_nxt;
            tail_q  <= tail_q + {{CKPT_IDX_W{1'b0}}, tail_adv};
            if (mispredict) begin
                tbl_q  <= slot_cdb[resolve_id];
                head_q <= rec_head;
            end else begin
                tbl_q  <= tbl_nxt;
                head_q <= head_q + {{CKPT_IDX_W{1'b0}}, take};
            end
        end
    end

    // Checkpoint storage: capture the snapshot on a take, otherwise keep the CDB-updated copy.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_CHECKPOINTS; k++) begin
            if (reset && !table_restore_en && !mispredict && take && (head_idx == CKPT_IDX_W'(k))) begin
                slot_q[k] <= snap_nxt;
            end else begin
                slot_q[k] <= slot_cdb[k];
            end
        end
    end

endmodule

// File: tb/tb_checkpoint_map_table.sv
// Bench for checkpoint_map_table: directed scenarios plus random traffic against a queue-based model.
// The model keeps live checkpoints as an age-ordered queue of whole-table copies.
// Every output is compared each cycle after the clock edge.
module tb_checkpoint_map_table;

    logic                 clock;
    logic                 reset;
    logic [1:0]           write_enables;
    logic [1:0][4:0]      write_addrs;
    logic [1:0][6:0]      write_phys_regs;
    logic [3:0][4:0]      read_addrs;
    logic [3:0][7:0]      read_entries;
    logic [1:0][7:0]      cdb_broadcasts;
    logic                 ckpt_req;
    logic [0:0]           ckpt_port;
    logic                 ckpt_avail;
    logic [1:0]           ckpt_id;
    logic                 resolve_valid;
    logic [1:0]           resolve_id;
    logic                 resolve_mispredict;
    logic                 table_restore_en;
    logic [31:0][7:0]     table_restore;
    logic [31:0][7:0]     table_snapshot;
    logic [2:0]           ckpt_count;

    checkpoint_map_table dut (
        .clock              (clock),
        .reset              (reset),
        .write_enables      (write_enables),
        .write_addrs        (write_addrs),
        .write_phys_regs    (write_phys_regs),
        .read_addrs         (read_addrs),
        .read_entries       (read_entries),
        .cdb_broadcasts     (cdb_broadcasts),
        .ckpt_req           (ckpt_req),
        .ckpt_port          (ckpt_port),
        .ckpt_avail         (ckpt_avail),
        .ckpt_id            (ckpt_id),
        .resolve_valid      (resolve_valid),
        .resolve_id         (resolve_id),
        .resolve_mispredict (resolve_mispredict),
        .table_restore_en   (table_restore_en),
        .table_restore      (table_restore),
        .table_snapshot     (table_snapshot),
        .ckpt_count         (ckpt_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: table as {tag, ready} bytes, checkpoints oldest-first in a queue.
    typedef struct packed {
        logic             live;
        logic [1:0]       id;
        logic [31:0][7:0] ent;
    } ck_t;

    logic [31:0][7:0] m_tbl;
    ck_t              q[$];
    logic [1:0]       m_next_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [6:0] t);
        bit h = 0;
        for (int c = 0; c < 2; c++)
            if (cdb_broadcasts[c][7] && cdb_broadcasts[c][6:0] == t) h = 1;
        return h;
    endfunction

    function automatic logic [31:0][7:0] cdb_upd(input logic [31:0][7:0] t);
        logic [31:0][7:0] r;
        r = t;
        for (int i = 0; i < 32; i++)
            if (hit(t[i][7:1])) r[i][0] = 1'b1;
        return r;
    endfunction

    function automatic bit m_avail();
        return (q.size() < 4) || !q[0].live;
    endfunction

    task automatic model_step();
        logic [31:0][7:0] nt, sn;
        int  fi;
        bit  pop, av;
        ck_t e;
        if (!reset) begin
            for (int i = 0; i < 32; i++) m_tbl[i] = {7'(i), 1'b1};
            q.delete();
            m_next_id = 0;
            return;
        end
        if (table_restore_en) begin
            m_tbl = table_restore;
            q.delete();
            m_next_id = 0;
            return;
        end
        av  = m_avail();
        pop = (q.size() > 0) && !q[0].live;
        fi  = -1;
        if (resolve_valid)
            for (int i = 0; i < q.size(); i++)
                if (q[i].live && q[i].id == resolve_id) fi = i;
        for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            e.ent = cdb_upd(e.ent);
            q[i] = e;
        end
        if (fi >= 0 && resolve_mispredict) begin
            m_tbl = q[fi].ent;
            while (q.size() > fi) void'(q.pop_back());
            if (pop) void'(q.pop_front());
            m_next_id = resolve_id;
        end else begin
            nt = cdb_upd(m_tbl);
            sn = nt;
            for (int p = 0; p < 2; p++) begin
                if (write_enables[p] && write_addrs[p] != 0) begin
                    nt[write_addrs[p]] = {write_phys_regs[p], hit(write_phys_regs[p])};
                    if (p <= int'(ckpt_port)) sn[write_addrs[p]] = {write_phys_regs[p], hit(write_phys_regs[p])};
                end
            end
            m_tbl = nt;
            if (fi >= 0) begin
                e = q[fi];
                e.live = 1'b0;
                q[fi] = e;
            end
            if (pop) void'(q.pop_front());
            if (ckpt_req && av) begin
                e.live = 1'b1;
                e.id   = m_next_id;
                e.ent  = sn;
                q.push_back(e);
                m_next_id = m_next_id + 2'd1;
            end
        end
    endtask

    task automatic check_all();
        check("ckpt_avail", {31'd0, ckpt_avail}, {31'd0, m_avail()});
        check("ckpt_id", {30'd0, ckpt_id}, {30'd0, m_next_id});
        check("ckpt_count", {29'd0, ckpt_count}, q.size());
        for (int r = 0; r < 4; r++)
            check($sformatf("read%0d", r), {24'd0, read_entries[r]}, {24'd0, m_tbl[read_addrs[r]]});
        for (int i = 0; i < 32; i++)
            check($sformatf("snap%0d", i), {24'd0, table_snapshot[i]}, {24'd0, m_tbl[i]});
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle();
        reset              = 1'b1;
        write_enables      = '0;
        write_addrs        = '0;
        write_phys_regs    = '0;
        cdb_broadcasts     = '0;
        ckpt_req           = 1'b0;
        ckpt_port          = 1'b0;
        resolve_valid      = 1'b0;
        resolve_id         = '0;
        resolve_mispredict = 1'b0;
        table_restore_en   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        cycle();
        idle();
    endtask

    task automatic drive_random();
        reset            = ($urandom_range(299) != 0);
        table_restore_en = ($urandom_range(59) == 0);
        if (table_restore_en)
            for (int i = 0; i < 32; i++) table_restore[i] = 8'($urandom);
        for (int p = 0; p < 2; p++) begin
            write_enables[p]   = 1'($urandom_range(1));
            write_addrs[p]     = 5'($urandom);
            write_phys_regs[p] = 7'($urandom_range(127, 32));
        end
        for (int c = 0; c < 2; c++) begin
            cdb_broadcasts[c][7]   = 1'($urandom_range(1));
            cdb_broadcasts[c][6:0] = ($urandom_range(1) == 1) ? m_tbl[$urandom_range(31)][7:1] : 7'($urandom);
        end
        ckpt_req  = ($urandom_range(1) == 1) && m_avail();
        ckpt_port = 1'($urandom_range(1));
        resolve_valid = ($urandom_range(2) == 0);
        if (q.size() > 0 && $urandom_range(3) != 0)
            resolve_id = q[$urandom_range(q.size() - 1)].id;
        else
            resolve_id = 2'($urandom);
        resolve_mispredict = ($urandom_range(4) == 0);
        for (int r = 0; r < 4; r++) read_addrs[r] = 5'($urandom);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0][7:0] tr;
        logic [1:0]       cid;
        table_restore = '0;
        read_addrs    = {5'd9, 5'd7, 5'd4, 5'd3};
        m_tbl         = '0;
        m_next_id     = 0;

        // Reset held for two cycles.
        idle();
        reset = 1'b0;
        cycle();
        cycle();
        idle();
        read_addrs[0] = 5'd5;
        #1;
        check("rst_x5", {24'd0, read_entries[0]}, {24'd0, 7'd5, 1'b1});
        check("rst_id", {30'd0, ckpt_id}, 0);
        check("rst_avail", {31'd0, ckpt_avail}, 1);
        check("rst_count", {29'd0, ckpt_count}, 0);
        read_addrs[0] = 5'd3;

        // Checkpoint includes only port 0; mispredict restores it.
        write_enables   = 2'b11;
        write_addrs     = {5'd4, 5'd3};
        write_phys_regs = {7'd41, 7'd40};
        ckpt_req        = 1'b1;
        ckpt_port       = 1'b0;
        cycle();
        idle();
        resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1;
        cycle();
        idle();
        check("mp_x3", {24'd0, table_snapshot[3]}, {24'd0, 7'd40, 1'b0});
        check("mp_x4", {24'd0, table_snapshot[4]}, {24'd0, 7'd4, 1'b1});

        // Checkpointed entry wakes up from the CDB before the restore.
        cid = ckpt_id;
        write_enables = 2'b01; write_addrs[0] = 5'd7; write_phys_regs[0] = 7'd50;
        ckpt_req = 1'b1; ckpt_port = 1'b1;
        cycle();
        idle();
        cycle();
        cdb_broadcasts[0] = {1'b1, 7'd50};
        cycle();
        idle();
        resolve_valid = 1'b1; resolve_id = cid; resolve_mispredict = 1'b1;
        cycle();
        idle();
        check("wake_x7", {24'd0, table_snapshot[7]}, {24'd0, 7'd50, 1'b1});

        // Fill all slots, free out of order, then free the oldest.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ckpt_req = 1'b1;
            cycle();
        end
        idle();
        check("full_avail", {31'd0, ckpt_avail}, 0);
        check("full_count", {29'd0, ckpt_count}, 4);
        resolve_valid = 1'b1; resolve_id = 2'd2;
        cycle();
        idle();
        cycle();
        check("ooo_avail", {31'd0, ckpt_avail}, 0);
        resolve_valid = 1'b1; resolve_id = 2'd0;
        cycle();
        idle();
        cycle();
        cycle();
        check("tail_avail", {31'd0, ckpt_avail}, 1);
        check("tail_count", {29'd0, ckpt_count}, 3);

        // Mispredict to id 1 kills younger slots and drops the same-cycle write.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            ckpt_req = 1'b1;
            cycle();
        end
        idle();
        resolve_valid = 1'b1; resolve_id = 2'd1; resolve_mispredict = 1'b1;
        write_enables = 2'b01; write_addrs[0] = 5'd9; write_phys_regs[0] = 7'd60;
        cycle();
        idle();
        check("kill_count", {29'd0, ckpt_count}, 1);
        check("kill_id", {30'd0, ckpt_id}, 1);
        check("kill_x9", {24'd0, table_snapshot[9]}, {24'd0, 7'd9, 1'b1});

        // Full restore outranks a mispredict and a write.
        for (int i = 0; i < 32; i++) tr[i] = 8'($urandom);
        table_restore = tr;
        table_restore_en = 1'b1;
        resolve_valid = 1'b1; resolve_id = 2'd0; resolve_mispredict = 1'b1;
        write_enables = 2'b11; write_addrs = {5'd2, 5'd1}; write_phys_regs = {7'd70, 7'd71};
        cycle();
        idle();
        check("rest_count", {29'd0, ckpt_count}, 0);
        for (int i = 0; i < 32; i++)
            check($sformatf("rest%0d", i), {24'd0, table_snapshot[i]}, {24'd0, tr[i]});

        // Writes to x0 are ignored.
        do_reset();
        write_enables = 2'b10; write_addrs[1] = 5'd0; write_phys_regs[1] = 7'd33;
        cycle();
        idle();
        check("x0", {24'd0, table_snapshot[0]}, {24'd0, 7'd0, 1'b1});

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            drive_random();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
